// File: rtl/cnn16_pkg.sv
// Shared definitions for the cnn16 RAM arbiter slice: default RAM geometry,
// arbiter state encoding and a pointer-width helper.
package cnn16_pkg;

    localparam int CNN16_DATA_WIDTH = 16;
    localparam int CNN16_ADDR_WIDTH = 12;

    // INIT exists only in builds that clear the RAM after reset
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ARB  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_t;

    // Width of a requester index; never narrower than one bit
    function automatic int ptr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn16_rr_pick.sv
// Combinational round-robin picker: grants the first valid requester at or
// after rr_ptr, searching upward and wrapping at NUM_REQ. One-hot output.
module cnn16_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant
);

    int   idx;
    logic found;

    // Walk the requesters starting at rr_ptr; the first valid one wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn16_ram_arb.sv
// Multi-requester arbiter in front of a single-port RAM with 1-cycle read
// latency. Round-robin arbitration with optional grant locking; read responses
// are tagged per requester one cycle after the transfer.
// Optional feature: define CNN16_RAM_CLEAR_EN to zero the whole RAM after reset
// (INIT state, init_busy high while clearing).
module cnn16_ram_arb
    import cnn16_pkg::*;
#(
    parameter int DATA_WIDTH = CNN16_DATA_WIDTH,
    parameter int ADDR_WIDTH = CNN16_ADDR_WIDTH,
    parameter int NUM_REQ    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          init_busy,
    output logic                          mem_write,
    output logic [ADDR_WIDTH-1:0]         address,
    output logic [DATA_WIDTH-1:0]         data_in,
    input  logic [DATA_WIDTH-1:0]         data_out
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    arb_state_t             state_reg;
    logic [PTR_W-1:0]       rr_ptr_reg;
    logic [PTR_W-1:0]       owner_reg;
    logic [NUM_REQ-1:0]     rsp_valid_reg;
`ifdef CNN16_RAM_CLEAR_EN
    logic [ADDR_WIDTH-1:0]  clr_cnt_reg;
`endif

    logic [NUM_REQ-1:0]     rr_grant;
    logic [NUM_REQ-1:0]     grant;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       ptr_next;
    logic                   xfer;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

    // Unpack the per-requester address and write-data slices
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    cnn16_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_reg),
        .grant  (rr_grant)
    );

    // Ready: round-robin in ARB, owner only in LOCK, nobody in INIT or reset
    always_comb begin
        grant = '0;
        if (!rst) begin
            case (state_reg)
                ST_ARB:  grant = rr_grant;
                ST_LOCK: grant = req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_reg);
                default: grant = '0;
            endcase
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;

    // One-hot grant to requester index, plus the round-robin successor
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = PTR_W'(i);
        end
        ptr_next = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
    end

    // RAM command: clear sweep during INIT, otherwise the granted requester
    always_comb begin
        mem_write = 1'b0;
        address   = '0;
        data_in   = '0;
        if (!rst) begin
`ifdef CNN16_RAM_CLEAR_EN
            if (state_reg == ST_INIT) begin
                mem_write = 1'b1;
                address   = clr_cnt_reg;
            end else
`endif
            if (xfer) begin
                mem_write = req_write[gnt_idx];
                address   = addr_arr[gnt_idx];
                data_in   = wdata_arr[gnt_idx];
            end
        end
    end

    // Arbitration state, lock ownership, clear sweep and response tagging
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef CNN16_RAM_CLEAR_EN
            state_reg   <= ST_INIT;
            clr_cnt_reg <= '0;
`else
            state_reg   <= ST_ARB;
`endif
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            rsp_valid_reg <= '0;
        end else begin
            rsp_valid_reg <= (xfer && !req_write[gnt_idx]) ? grant : '0;
            case (state_reg)
`ifdef CNN16_RAM_CLEAR_EN
                ST_INIT: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (&clr_cnt_reg) state_reg <= ST_ARB;
                end
`endif
                ST_ARB: begin
                    if (xfer) begin
                        if (req_lock[gnt_idx]) begin
                            state_reg <= ST_LOCK;
                            owner_reg <= gnt_idx;
                        end else begin
                            rr_ptr_reg <= ptr_next;
                        end
                    end
                end
                ST_LOCK: begin
                    if (xfer && !req_lock[gnt_idx]) begin
                        state_reg  <= ST_ARB;
                        rr_ptr_reg <= ptr_next;
                    end
                end
                default: state_reg <= ST_ARB;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = data_out;

`ifdef CNN16_RAM_CLEAR_EN
    assign init_busy = (state_reg == ST_INIT);
`else
    assign init_busy = 1'b0;
`endif

endmodule

// File: doc/cnn16_ram_arb.md
CNN16_RAM_ARB -- requirements
Module: cnn16_ram_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, giving the RAM address width (2^ADDR_WIDTH words).
REQ-003 SHALL have parameter NUM_REQ, default 3, giving the number of requesters (range 2..8).
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk  in  1  clock, rising edge; rst  in  1  reset.
REQ-005 SHALL have ports: req_valid  in  NUM_REQ  per-requester command valid; req_write  in  NUM_REQ  1 = write, 0 = read; req_lock  in  NUM_REQ  hold grant after this beat.
REQ-006 SHALL have ports: req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i in slice i; req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-007 SHALL have ports: req_ready  out  NUM_REQ  beat accepted; rsp_valid  out  NUM_REQ  read data valid; rsp_rdata  out  DATA_WIDTH  read data, shared; init_busy  out  1  clear in progress.
REQ-008 SHALL have RAM-side ports: mem_write  out  1; address  out  ADDR_WIDTH; data_in  out  DATA_WIDTH; data_out  in  DATA_WIDTH. The attached single-port RAM has registered read data, 1-cycle latency, and reads only when mem_write=0.

Function
REQ-009 SHALL raise at most one req_ready bit per cycle; a beat transfers when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-010 SHALL drive req_ready combinationally. In state ARB, ready goes to the first valid requester at or after rr_ptr, searching upward and wrapping at NUM_REQ.
REQ-011 SHALL drive address, data_in and mem_write=req_write[i] from granted requester i in the same cycle. With no transfer: mem_write=0, address=0, data_in=0.
REQ-012 SHALL set rr_ptr to (i+1) mod NUM_REQ after a transfer from requester i with req_lock[i]=0, and hold rr_ptr otherwise.
REQ-013 SHALL enter state LOCK with owner=i on a transfer with req_lock[i]=1. In LOCK, only the owner can receive ready, even while other requesters are valid. The owner dropping req_valid keeps LOCK; there is no timeout.
REQ-014 SHALL leave LOCK to ARB on an owner transfer with req_lock=0, and advance rr_ptr past the owner.
REQ-015 SHALL assert rsp_valid[i] for exactly one cycle, cycle k+1, for a read transfer from requester i at edge k. Back-to-back reads each produce their own response; responses have no backpressure.
REQ-016 SHALL drive rsp_rdata = data_out continuously; rsp_rdata is meaningful only while a rsp_valid bit is high.
REQ-017 SHALL return the newly written data for a write at edge k followed by a read of the same address at edge k+1.
REQ-018 SHALL keep all rsp_valid bits low in cycles that follow a write or an idle cycle.

Reset
REQ-019 SHALL, while rst=1: force req_ready=0, mem_write=0, address=0, data_in=0. After the reset edge: rsp_valid=0, rr_ptr=0, lock cleared, state = INIT if CNN16_RAM_CLEAR_EN is defined, else ARB.
REQ-020 SHALL, on reset mid-operation, discard any pending read response (no rsp_valid in the cycle after reset) and abort any lock or clear in progress.

Configuration
REQ-021 SHALL, with CNN16_RAM_CLEAR_EN defined, enter INIT after reset. INIT writes 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle, using mem_write=1 and address=clear counter. During INIT: req_ready=0 and init_busy=1. After the last address is written, the state goes to ARB.
REQ-022 SHALL, without CNN16_RAM_CLEAR_EN, omit the INIT state and clear counter, tie init_busy to 0, and leave RAM contents undefined after power-up.

Structure
REQ-023 SHALL take DATA_WIDTH/ADDR_WIDTH defaults and the state encoding (INIT, ARB, LOCK) from shared package cnn16_pkg.
REQ-024 SHALL place round-robin selection (valid vector and rr_ptr in, one-hot grant out) in combinational sub-module cnn16_rr_pick.

Verification
REQ-025 SHALL cover: all three requesters valid for reads continuously -> grants in order 0,1,2,0,1,2; each rsp_valid appears exactly one cycle after its grant.
REQ-026 SHALL cover: requester 1 writes 0xBEEF to 0x123, then requester 2 reads 0x123 on the next cycle -> rsp_valid[2] with rsp_rdata=0xBEEF.
REQ-027 SHALL cover: requester 0 issues 4 beats with req_lock=1,1,1,0 while requesters 1 and 2 stay valid -> requester 0 gets 4 consecutive grants, then requester 1 is granted.
REQ-028 SHALL cover: rst asserted for one cycle immediately after a read grant -> no rsp_valid the next cycle, rr_ptr=0, the first grant goes to requester 0.
REQ-029 SHALL cover, with CNN16_RAM_CLEAR_EN: release reset -> init_busy high for 4096 cycles, no req_ready during that time, then a read of 0xFFF returns 0x0000.
